// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
// State encodings and the default operand width.
package serial_subtractor_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: {bo,d} = x - y - bi.
// Purely combinational; the serial datapath uses one instance.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  // Difference and borrow-out of a single bit position
  always_comb begin
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: {bout,diff} = a - b - bin, LSB first.
// One bit per cycle through a full_subtractor and a borrow flop.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             diff_bit
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic fs_d, fs_bo;

  full_subtractor u_fs (
    .x  (a_sh_q[0]),
    .y  (b_sh_q[0]),
    .bi (brw_q),
    .d  (fs_d),
    .bo (fs_bo)
  );

  // Next-state: accept in IDLE, shift one bit per RUN edge, pulse DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    brw_d   = brw_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          brw_d   = bin;
          cnt_d   = '0;
          diff_d  = '0;
          bout_d  = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        diff_d = {fs_d, diff_q[WIDTH-1:1]};
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        brw_d  = fs_bo;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          bout_d  = fs_bo;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      brw_q   <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      brw_q   <= brw_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  // Status decoded from the registered state; bit tap gated to RUN
  always_comb begin
    busy     = (state_q == ST_RUN);
    done     = (state_q == ST_DONE);
    diff     = diff_q;
    bout     = bout_q;
    diff_bit = (state_q == ST_RUN) & fs_d;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8).
// Directed vectors; monitor pops expectations on done.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done, bout, diff_bit;
  logic [W-1:0] diff;

  logic fx, fy, fbi, fd, fbo;

  int   checks;
  int   errors;
  exp_t sb[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .bout     (bout),
    .diff_bit (diff_bit)
  );

  full_subtractor u_fs (
    .x  (fx),
    .y  (fy),
    .bi (fbi),
    .d  (fd),
    .bo (fbo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: collects the diff_bit stream while busy, checks on done
  logic [W-1:0] bits;
  int           nbusy;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      bits  = '0;
      nbusy = 0;
    end else if (busy) begin
      bits = {diff_bit, bits[W-1:1]};
      nbusy++;
    end else if (done) begin
      chk("busy_with_done", {31'd0, busy}, 32'd0);
      chk("busy_cycles", nbusy, W);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("diff", {24'd0, diff}, {24'd0, e.diff});
        chk("bout", {31'd0, bout}, {31'd0, e.bout});
        chk("bit_stream", {24'd0, bits}, {24'd0, e.diff});
      end
      bits  = '0;
      nbusy = 0;
    end
  end

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ibin, input logic [W-1:0] ed,
                       input logic eb);
    @(negedge clk);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    sb.push_back('{diff: ed, bout: eb});
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
  endtask

  initial begin
    int v;
    checks = 0; errors = 0;
    bits = '0; nbusy = 0;
    rst_n = 1'b1; start = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    fx = 1'b0; fy = 1'b0; fbi = 1'b0;

    // Exhaustive truth table of the bit slice
    for (int i = 0; i < 8; i++) begin
      {fx, fy, fbi} = 3'(i);
      #1;
      v = int'(fx) - int'(fy) - int'(fbi);
      chk("fs_d", {31'd0, fd}, {31'd0, v[0]});
      chk("fs_bo", {31'd0, fbo}, (v < 0) ? 32'd1 : 32'd0);
    end

    // Asynchronous reset, checked before any clock edge acts
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_diff", {24'd0, diff}, 32'd0);
    chk("rst_bout", {31'd0, bout}, 32'd0);
    chk("rst_dbit", {31'd0, diff_bit}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic op and borrow/wrap cases
    issue(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0);
    repeat (3) @(negedge clk);
    chk("diff_hold_idle", {24'd0, diff}, 32'h37);
    issue(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    issue(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1);
    issue(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);

    // Start pulse during RUN is ignored
    @(negedge clk);
    a = 8'h5A; b = 8'h23; bin = 1'b0; start = 1'b1;
    sb.push_back('{diff: 8'h37, bout: 1'b0});
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'h11; b = 8'h22; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Start raised during DONE and held: accepted on the IDLE edge
    a = 8'h00; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    chk("done_start_busy", {31'd0, busy}, 32'd0);
    chk("done_start_diff", {24'd0, diff}, 32'h37);
    sb.push_back('{diff: 8'hFF, bout: 1'b1});
    @(negedge clk);
    chk("held_accept_busy", {31'd0, busy}, 32'd1);
    chk("held_accept_diff", {24'd0, diff}, 32'h00);
    start = 1'b0;
    wait_done();

    // Abort mid-RUN: no done pulse, outputs cleared
    @(negedge clk);
    a = 8'h80; b = 8'h7F; bin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_diff", {24'd0, diff}, 32'd0);
    chk("abort_bout", {31'd0, bout}, 32'd0);
    chk("abort_dbit", {31'd0, diff_bit}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_idle_busy", {31'd0, busy}, 32'd0);

    issue(8'hFF, 8'h0F, 1'b0, 8'hF0, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
